// File: rtl/demux1x2_buf_pkg.sv
// rtl/demux1x2_buf_pkg.sv - shared constants for the 1-to-2 buffered demux
//
// Purpose: holds the datapath default word width shared with the select mux
// and other datapath blocks, plus the select encodings for the demux.
// Ports: none (package).
package demux1x2_buf_pkg;

  localparam int DEFAULT_DATA_BITS = 32;

  localparam logic DEMUX_PORT0 = 1'b0;
  localparam logic DEMUX_PORT1 = 1'b1;

endpackage

// File: rtl/demux1x2_buf_out_fifo.sv
// rtl/demux1x2_buf_out_fifo.sv - per-destination output buffer of the demux
//
// Purpose: DEPTH-entry FIFO with registered head outputs, one per demux port.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   push, push_data      write request and word (ignored when full)
//   pop                  consumer ready (ignored when empty)
//   valid, data          head entry valid / head entry word
//   not_full             at least one free slot
module demux_out_fifo
  import demux1x2_buf_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 not_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 do_push;
  logic                 do_pop;

  // Full/empty guards are evaluated on the registered count, so a pop in the
  // same cycle never makes room for a push that cycle.
  assign do_push = push && (count_q != FULL_CNT);
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Head outputs come straight from registers/storage: no push-to-output bypass.
  assign valid    = (count_q != '0);
  assign data     = mem_q[rd_ptr_q];
  assign not_full = (count_q != FULL_CNT);

endmodule

// File: rtl/demux1x2_buf.sv
// rtl/demux1x2_buf.sv - registered 1-to-2 demultiplexer with per-port buffers
//
// Purpose: routes each accepted input word to port 0 or port 1 by s_sel; each
// port has its own FIFO so back-pressure on one port never stalls the other.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   s_valid, s_ready, s_sel,      input stream handshake, destination select,
//   s_data                        and word
//   m0_valid, m0_ready, m0_data   port 0 output stream
//   m1_valid, m1_ready, m1_data   port 1 output stream
//   busy                          either buffer holds a word
module demux1x2_buf
  import demux1x2_buf_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_sel,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 m0_valid,
  input  logic                 m0_ready,
  output logic [DATA_BITS-1:0] m0_data,
  output logic                 m1_valid,
  input  logic                 m1_ready,
  output logic [DATA_BITS-1:0] m1_data,
  output logic                 busy
);

  logic not_full0, not_full1;
  logic push0, push1;

  // s_ready depends only on s_sel and the selected port's registered count.
  assign s_ready = (s_sel == DEMUX_PORT1) ? not_full1 : not_full0;

  assign push0 = s_valid && s_ready && (s_sel == DEMUX_PORT0);
  assign push1 = s_valid && s_ready && (s_sel == DEMUX_PORT1);

  demux_out_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (s_data),
    .pop       (m0_ready),
    .valid     (m0_valid),
    .data      (m0_data),
    .not_full  (not_full0)
  );

  demux_out_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (s_data),
    .pop       (m1_ready),
    .valid     (m1_valid),
    .data      (m1_data),
    .not_full  (not_full1)
  );

  // Valid flags are registered-count derived, so busy is too.
  assign busy = m0_valid || m1_valid;

endmodule

// File: tb/tb_demux1x2_buf.sv
// tb/tb_demux1x2_buf.sv - self-checking bench for demux1x2_buf
module tb_demux1x2_buf;

  localparam int DB    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_sel = 1'b0;
  logic [DB-1:0] s_data = '0;
  logic          m0_valid, m1_valid;
  logic          m0_ready = 1'b0, m1_ready = 1'b0;
  logic [DB-1:0] m0_data, m1_data;
  logic          busy;

  int checks = 0;
  int failures = 0;

  // Reference model: one bounded queue per destination port.
  logic [DB-1:0] q0[$];
  logic [DB-1:0] q1[$];

  demux1x2_buf #(.DATA_BITS(DB), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_sel    (s_sel),
    .s_data   (s_data),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m0_data  (m0_data),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .m1_data  (m1_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Apply this cycle's handshakes to the model, then advance one clock.
  // Acceptance uses occupancy before any pop, so a full port refuses a push
  // even when it is popped in the same cycle.
  task automatic tick();
    bit acc, p0, p1;
    acc = s_valid && ((s_sel ? q1.size() : q0.size()) < DEPTH);
    p0  = m0_ready && (q0.size() != 0);
    p1  = m1_ready && (q1.size() != 0);
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (acc) begin
      if (s_sel) q1.push_back(s_data);
      else       q0.push_back(s_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    q0.delete(); q1.delete();
    s_valid = 1'b0; m0_ready = 1'b0; m1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    for (int s = 0; s < 2; s++) begin
      s_sel = s[0];
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_s_ready sel=%0d: got %b expected 1", s, s_ready);
      end
    end
    checks++;
    if ({m0_valid, m1_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_valid_busy: got %b expected 000", {m0_valid, m1_valid, busy});
    end
    checks++;
    if (m0_data !== '0 || m1_data !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h/%h expected 0/0", m0_data, m1_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    s_valid = 1'b1; s_sel = 1'b0; s_data = 32'hDEADBEEF; m0_ready = 1'b1; m1_ready = 1'b0;
    #1;
    checks++;
    if (m0_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_no_bypass: got m0_valid=%b expected 0", m0_valid);
    end
    tick();
    s_valid = 1'b0;
    checks++;
    if (m0_valid !== 1'b1 || m0_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL single_out: got %b/%h expected 1/deadbeef", m0_valid, m0_data);
    end
    checks++;
    if (m1_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_m1_busy: got m1_valid=%b busy=%b expected 0/1", m1_valid, busy);
    end
    tick();
    checks++;
    if (m0_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: got m0_valid=%b busy=%b expected 0/0", m0_valid, busy);
    end
  endtask

  task automatic test_fill_port1();
    logic [DB-1:0] exp1 [2];
    exp1[0] = 32'h11; exp1[1] = 32'h22;
    m0_ready = 1'b0; m1_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_sel = 1'b1; s_data = exp1[i];
      tick();
    end
    s_data = 32'h44;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_sready_port1: got %b expected 0", s_ready);
    end
    s_sel = 1'b0; s_data = 32'h33;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_sready_port0: got %b expected 1", s_ready);
    end
    tick();
    s_valid = 1'b0;
    checks++;
    if (m0_valid !== 1'b1 || m0_data !== 32'h33) begin
      failures++;
      $display("FAIL fill_port0_word: got %b/%h expected 1/33", m0_valid, m0_data);
    end
    m1_ready = 1'b1; m0_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (m1_valid !== 1'b1 || m1_data !== exp1[i]) begin
        failures++;
        $display("FAIL fill_drain_%0d: got %b/%h expected 1/%h", i, m1_valid, m1_data, exp1[i]);
      end
      tick();
    end
    checks++;
    if (m1_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fill_empty: got m1_valid=%b busy=%b expected 0/0", m1_valid, busy);
    end
    m1_ready = 1'b0; m0_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    logic [DB-1:0] w [3];
    w[0] = 32'hA0A0_0001; w[1] = 32'hB0B0_0002; w[2] = 32'hC0C0_0003;
    m0_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_sel = 1'b0; s_data = w[i];
      tick();
    end
    s_data = w[2]; m0_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0 || m0_data !== w[0]) begin
      failures++;
      $display("FAIL fullpop_refuse: got s_ready=%b data=%h expected 0/%h", s_ready, m0_data, w[0]);
    end
    tick();
    checks++;
    if (s_ready !== 1'b1 || m0_data !== w[1]) begin
      failures++;
      $display("FAIL fullpop_accept: got s_ready=%b data=%h expected 1/%h", s_ready, m0_data, w[1]);
    end
    tick();
    s_valid = 1'b0;
    checks++;
    if (m0_valid !== 1'b1 || m0_data !== w[2]) begin
      failures++;
      $display("FAIL fullpop_order: got %b/%h expected 1/%h", m0_valid, m0_data, w[2]);
    end
    tick();
    checks++;
    if (m0_valid !== 1'b0) begin
      failures++;
      $display("FAIL fullpop_empty: got %b expected 0", m0_valid);
    end
    m0_ready = 1'b0;
  endtask

  task automatic test_interleave();
    m0_ready = 1'b1; m1_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_sel = i[0]; s_data = DB'(i);
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
        failures++;
        $display("FAIL inter_sready_%0d: got %b expected 1", i, s_ready);
      end
      tick();
      checks++;
      if (i[0] == 1'b0) begin
        if (m0_valid !== 1'b1 || m0_data !== DB'(i) || (i > 0 && m1_valid !== 1'b0)) begin
          failures++;
          $display("FAIL inter_word_%0d: got m0=%b/%h m1_valid=%b expected 1/%h", i, m0_valid, m0_data, m1_valid, i);
        end
      end else begin
        if (m1_valid !== 1'b1 || m1_data !== DB'(i) || m0_valid !== 1'b0) begin
          failures++;
          $display("FAIL inter_word_%0d: got m1=%b/%h m0_valid=%b expected 1/%h", i, m1_valid, m1_data, m0_valid, i);
        end
      end
    end
    s_valid = 1'b0;
    tick();
    m0_ready = 1'b0; m1_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    m0_ready = 1'b0; m1_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_sel = i[0]; s_data = 32'h5000 + DB'(i);
      tick();
    end
    s_valid = 1'b0;
    #1;
    checks++;
    if ({m0_valid, m1_valid, busy} !== 3'b111) begin
      failures++;
      $display("FAIL mid_prefill: got %b expected 111", {m0_valid, m1_valid, busy});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({m0_valid, m1_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL mid_async_drop: got %b expected 000", {m0_valid, m1_valid, busy});
    end
    q0.delete(); q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if ({m0_valid, m1_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL mid_no_stale: got %b expected 000", {m0_valid, m1_valid, busy});
    end
    s_valid = 1'b1; s_sel = 1'b1; s_data = 32'hFACE;
    tick();
    s_valid = 1'b0;
    checks++;
    if (m1_valid !== 1'b1 || m1_data !== 32'hFACE || m0_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_fresh: got m1=%b/%h m0_valid=%b expected 1/face/0", m1_valid, m1_data, m0_valid);
    end
    m1_ready = 1'b1;
    tick();
    m1_ready = 1'b0;
  endtask

  task automatic test_random();
    bit hold;
    hold = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!hold) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_sel   = $urandom_range(0, 1);
        s_data  = $urandom;
      end
      m0_ready = ($urandom_range(0, 2) != 0);
      m1_ready = ($urandom_range(0, 2) == 0);
      #1;
      checks++;
      if (s_ready !== ((s_sel ? q1.size() : q0.size()) < DEPTH)) begin
        failures++;
        $display("FAIL rnd_sready c=%0d: got %b expected %b", c, s_ready, (s_sel ? q1.size() : q0.size()) < DEPTH);
      end
      checks++;
      if (m0_valid !== (q0.size() != 0) || (q0.size() != 0 && m0_data !== q0[0])) begin
        failures++;
        $display("FAIL rnd_port0 c=%0d: got %b/%h expected %b/%h", c, m0_valid, m0_data, q0.size() != 0, (q0.size() != 0) ? q0[0] : '0);
      end
      checks++;
      if (m1_valid !== (q1.size() != 0) || (q1.size() != 0 && m1_data !== q1[0])) begin
        failures++;
        $display("FAIL rnd_port1 c=%0d: got %b/%h expected %b/%h", c, m1_valid, m1_data, q1.size() != 0, (q1.size() != 0) ? q1[0] : '0);
      end
      checks++;
      if (busy !== (q0.size() + q1.size() != 0)) begin
        failures++;
        $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, q0.size() + q1.size() != 0);
      end
      hold = s_valid && ((s_sel ? q1.size() : q0.size()) >= DEPTH);
      tick();
    end
    s_valid = 1'b0; m0_ready = 1'b0; m1_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_port1();
    test_full_pop();
    test_interleave();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux1x2_buf.md
Name: demux1x2_buf

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshake. It is the splitting counterpart of the 2:1 select mux.
- Takes one input stream plus a select bit and routes each word to output port 0 or port 1. Each port has its own small FIFO buffer.
- Used wherever one pipeline producer feeds two consumers, e.g. a memory response split to the load path or the fetch path.
- Gives registered outputs and independent back-pressure per destination.

Parameters:
- DATA_BITS, 32, width of the data word.
- DEPTH, 2, entries per output buffer. Must be a power of two and at least 2.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  input word valid.
- s_ready  output  1  input word accepted when s_valid && s_ready.
- s_sel  input  1  destination: 0 = port 0, 1 = port 1.
- s_data  input  DATA_BITS  input word.
- m0_valid  output  1  port 0 head entry valid.
- m0_ready  input  1  port 0 consumer ready.
- m0_data  output  DATA_BITS  port 0 head entry.
- m1_valid  output  1  port 1 head entry valid.
- m1_ready  input  1  port 1 consumer ready.
- m1_data  output  DATA_BITS  port 1 head entry.
- busy  output  1  high when either buffer holds at least one entry.

Behaviour:
- Reset, asynchronous on rst high:
  - both buffers emptied; counts = 0; read/write pointers = 0; storage cleared to 0.
  - outputs: m0_valid = m1_valid = 0, m0_data = m1_data = 0, busy = 0.
  - s_ready is combinational and reads 1 during reset release.
- Reset mid-operation discards all buffered words. No partial handshake survives.
- Input ready: s_ready = (count[s_sel] < DEPTH).
  - This is a combinational path from s_sel only. There is no path from m*_ready to s_ready.
  - A full port does not block traffic to the other port.
- Push happens on s_valid && s_ready. The word is written at wr_ptr[s_sel], then that port's wr_ptr and count are incremented.
- Pop on port k happens on mk_valid && mk_ready. That port's rd_ptr is incremented and its count decremented.
- mk_valid = (count[k] != 0) and mk_data = mem_k[rd_ptr_k]. Both are driven from registers/storage only.
- Latency: a word pushed in cycle N is visible on mk_valid/mk_data in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop on the same port when not full: count unchanged, both pointers advance.
- Full port with a pop in the same cycle: the push is not accepted, because s_ready was already 0. The port has one free slot in the next cycle.
- Empty port: mk_ready is ignored and no pop occurs.
- Pointers are clog2(DEPTH) bits and wrap naturally at DEPTH. Count is clog2(DEPTH)+1 bits and ranges 0..DEPTH.
- Ordering: words are delivered in order within each port. There is no ordering guarantee between ports.
- Source rule: while s_valid && !s_ready, the source holds s_valid, s_sel and s_data stable.
- busy = (count0 != 0) || (count1 != 0), registered-derived.

Decomposition:
- Shared package/header holds:
  - the default DATA_BITS (32), shared with the mux and other datapath blocks;
  - the DEMUX_PORT0 = 1'b0 and DEMUX_PORT1 = 1'b1 select encodings.
- One natural sub-module, demux_out_fifo, instantiated twice:
  - DEPTH-entry storage, pointers and count;
  - push/pop interface;
  - valid/data/not_full outputs.
- The top level holds only the s_ready select, push steering and busy.

Test Plan:
- Reset then single word: rst pulse; s_sel=0, s_data=32'hDEADBEEF for 1 cycle, m0_ready=1 -> m0_valid=1 and m0_data=32'hDEADBEEF in the next cycle only; m1_valid stays 0; busy 0 afterwards.
- Fill port 1: m1_ready=0; push 32'h11, 32'h22 -> s_ready=0 for s_sel=1 but 1 for s_sel=0. Push 32'h33 to port 0, accepted. Release m1_ready -> 32'h11 then 32'h22 drained in order.
- Full with pop in same cycle: port 0 full (DEPTH=2), m0_ready=1, s_valid=1, s_sel=0 -> push refused that cycle and accepted the following cycle; order preserved.
- Interleaved stream: 8 words 0..7 with s_sel alternating, both readies high -> port 0 receives 0,2,4,6 and port 1 receives 1,3,5,7, one per cycle, no bubbles after the first.
- Reset mid-operation: both ports holding 2 words; assert rst asynchronously mid-cycle -> m0_valid, m1_valid and busy drop immediately; no stale data after release.
- Random back-pressure, 1000 cycles, random s_sel/readies -> scoreboard matches per-port order; counts never exceed DEPTH.
